sevenseg_scan_ctrl: RTL

- Sequencer that time-multiplexes the shared seven-segment bus between the two digits of the dual display.
- Selects which 4-bit value feeds the shared hex decoder and drives the two digit enables.
- Enforces break-before-make blanking between digits so no ghosting occurs.
- Accepts new digit values only at frame boundaries via a req/ack handshake, so both digits always show a consistent pair.

---
 rtl/sevenseg_scan_ctrl_if.sv | 25 ++
 rtl/sevenseg_scan_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Digit-value handshake and display-drive bundle for sevenseg_scan_ctrl.
// With SEVENSEG_DIM_EN defined the bundle also carries the dim request.
interface sevenseg_scan_ctrl_if;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       upd_req;
    logic       upd_ack;
    logic [3:0] nibble;
    logic       enseg1;
    logic       enseg2;
    logic       frame_tick;
`ifdef SEVENSEG_DIM_EN
    logic       dim;

    modport master (output d0, d1, upd_req, dim,
                    input  upd_ack, nibble, enseg1, enseg2, frame_tick);
    modport slave  (input  d0, d1, upd_req, dim,
                    output upd_ack, nibble, enseg1, enseg2, frame_tick);
`else
    modport master (output d0, d1, upd_req,
                    input  upd_ack, nibble, enseg1, enseg2, frame_tick);
    modport slave  (input  d0, d1, upd_req,
                    output upd_ack, nibble, enseg1, enseg2, frame_tick);
`endif
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Dual-digit seven-segment scan sequencer with break-before-make blanking and
// frame-aligned req/ack digit loading. Optional half-duty dimming: SEVENSEG_DIM_EN.
module sevenseg_scan_ctrl #(
    parameter int ON_CYCLES    = 24000,
    parameter int BLANK_CYCLES = 240,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    sevenseg_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        SHOW0   = 2'd0,
        BLANK01 = 2'd1,
        SHOW1   = 2'd2,
        BLANK10 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ON_LD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
`ifdef SEVENSEG_DIM_EN
    localparam int               DIM_ON   = (ON_CYCLES / 2 < 1) ? 1 : ON_CYCLES / 2;
    localparam logic [CNT_W-1:0] DIM_THR  = CNT_W'(ON_CYCLES - DIM_ON);
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_d0, r_d1, r_nibble;
    logic [3:0]       w_d0_nxt, w_d1_nxt, w_nibble_nxt;
    logic             r_en1_n, r_en2_n, r_ack, r_tick;
    logic             w_en1_n_nxt, w_en2_n_nxt, w_ack_nxt, w_tick_nxt;
    logic             w_adv, w_lit;
`ifdef SEVENSEG_DIM_EN
    logic             r_dim, w_dim_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= BLANK10;
            r_cnt    <= BLANK_LD;
            r_d0     <= 4'd0;
            r_d1     <= 4'd0;
            r_nibble <= 4'd0;
            r_en1_n  <= 1'b1;
            r_en2_n  <= 1'b1;
            r_ack    <= 1'b0;
            r_tick   <= 1'b0;
`ifdef SEVENSEG_DIM_EN
            r_dim    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_d0     <= w_d0_nxt;
            r_d1     <= w_d1_nxt;
            r_nibble <= w_nibble_nxt;
            r_en1_n  <= w_en1_n_nxt;
            r_en2_n  <= w_en2_n_nxt;
            r_ack    <= w_ack_nxt;
            r_tick   <= w_tick_nxt;
`ifdef SEVENSEG_DIM_EN
            r_dim    <= w_dim_nxt;
`endif
        end
    end

    // The counter only reloads on a state change, so each phase lasts its load + 1 cycles.
    always_comb begin
        w_adv       = (r_cnt == '0);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        if (w_adv) begin
            case (r_state)
                SHOW0:   begin w_state_nxt = BLANK01; w_cnt_nxt = BLANK_LD; end
                BLANK01: begin w_state_nxt = SHOW1;   w_cnt_nxt = ON_LD;    end
                SHOW1:   begin w_state_nxt = BLANK10; w_cnt_nxt = BLANK_LD; end
                BLANK10: begin w_state_nxt = SHOW0;   w_cnt_nxt = ON_LD;    end
                default: begin w_state_nxt = BLANK10; w_cnt_nxt = BLANK_LD; end
            endcase
        end
    end

    // Outputs are computed from the next state so the registered enables line up with r_state.
    always_comb begin
        w_d0_nxt     = r_d0;
        w_d1_nxt     = r_d1;
        w_nibble_nxt = r_nibble;
        w_ack_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;
        if (w_adv) begin
            case (r_state)
                SHOW0:   w_nibble_nxt = r_d1;
                SHOW1: begin
                    if (bus.upd_req) begin
                        w_d0_nxt  = bus.d0;
                        w_d1_nxt  = bus.d1;
                        w_ack_nxt = 1'b1;
                    end
                    w_nibble_nxt = bus.upd_req ? bus.d0 : r_d0;
                end
                BLANK10: w_tick_nxt = 1'b1;
                default: ;
            endcase
        end
`ifdef SEVENSEG_DIM_EN
        w_dim_nxt = (w_adv && (r_state == BLANK01 || r_state == BLANK10)) ? bus.dim : r_dim;
        w_lit     = !w_dim_nxt || (w_cnt_nxt >= DIM_THR);
`else
        w_lit     = 1'b1;
`endif
        w_en1_n_nxt = !((w_state_nxt == SHOW0) && w_lit);
        w_en2_n_nxt = !((w_state_nxt == SHOW1) && w_lit);
    end

    assign bus.upd_ack    = r_ack;
    assign bus.nibble     = r_nibble;
    assign bus.enseg1     = r_en1_n;
    assign bus.enseg2     = r_en2_n;
    assign bus.frame_tick = r_tick;

endmodule
